adder_tree: RTL and testbench
=============================

# adder_tree

Pipelined, parameterised adder tree that reduces a 2-D array of signed fixed-point products to one sum per output column. Each cycle it accepts INPUT_SIZE × OUTPUT_SIZE operands and produces OUTPUT_SIZE column sums after a fixed latency. It is the accumulation stage of the dense latency layer, between the per-weight shift-add multipliers and the bias-add/output register.

## Interface

Parameters:
- WIDTH, 17, operand and result word width (signed two's complement, fixed point is transparent to this block)
- INPUT_SIZE, 32, number of rows summed per column (≥1)
- OUTPUT_SIZE, 1, number of independent columns (≥1)

Ports:
- clk  input  1  single clock; all registers on rising edge
- reset  input  1  asynchronous, active-high; clears every pipeline register
- input_data  input  signed [WIDTH-1:0] [0:INPUT_SIZE-1][0:OUTPUT_SIZE-1]  operand array, row-major (row = input index, col = output index)
- output_data  output  signed [WIDTH-1:0] [0:OUTPUT_SIZE-1]  output_data[c] = Σ_r input_data[r][c]

## Operation

- Columns are fully independent; one identical tree per column.
- Tree is binary: level 0 holds the INPUT_SIZE operands; each level adds adjacent pairs (2k, 2k+1) into element k of the next level.
- Odd element count at a level: last unpaired element is passed unchanged (registered) to the next level.
- Every level boundary is a register stage; level count L = ceil(log2(INPUT_SIZE)).
- INPUT_SIZE = 1: operand is passed through one register stage (L treated as 1).
- Arithmetic: every addition is WIDTH bits; default result wraps modulo 2^WIDTH (carry discarded, no widening between levels).
- Inputs are combinationally sampled at the first register stage; no input register beyond that.
- Fully pipelined: new operand set accepted every cycle; no valid/ready handshake, no stalls.
- Output is the last register stage directly (registered output, no combinational path from input_data to output_data).

## Timing

- Latency: max(L,1) clock cycles from input_data presented before edge n to output_data valid after edge n+max(L,1)-1.
  - INPUT_SIZE=7 → 3 cycles; 32 → 5; 2 → 1; 1 → 1.
- Throughput: one result set per cycle.
- Reset asserted: all stage registers and output_data go to 0 immediately (asynchronous), held while reset is high.
- Reset released: output_data stays 0 until the first operand set captured after release has propagated through all stages; intermediate stages hold zeros, so partial results never mix with pre-reset data.
- Reset mid-operation: all in-flight sums are discarded; no stale value appears on output_data after release.

## Configuration

- ADDER_TREE_SATURATE_EN defined: every adder saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1] on signed overflow, per level (saturation applied at each level, not just at output).
- Not defined: wrap-around modulo 2^WIDTH as described above. Latency is identical in both builds.

## Test plan

- WIDTH=8, INPUT_SIZE=7, OUTPUT_SIZE=5, every column rows = {-1,2,-3,4,-5,6,-7} → all output_data = -4 exactly 3 cycles later; 0 before.
- Same config, column c rows all = c+1 → output_data = {7,14,21,28,35}; verifies column independence.
- WIDTH=8, INPUT_SIZE=8, all rows = 100 → output 32 (wrap) without macro; 127 with ADDER_TREE_SATURATE_EN; all rows = -100 → -32 / -128.
- Streaming: new operand set each cycle (sums 1,2,3,...) → outputs appear in order, one per cycle, no gaps or duplicates.
- Assert reset while the pipeline is full → output_data = 0 immediately; after release, first nonzero output equals the first set applied post-release, L cycles later.
- INPUT_SIZE=1, input 5 → output 5 after 1 cycle; INPUT_SIZE=2, inputs {3,-4} → -1 after 1 cycle.

Source files
------------

// File: rtl/adder_tree.sv
// Pipelined binary adder tree: sums INPUT_SIZE signed rows per column, one register per tree level.
// Optional ADDER_TREE_SATURATE_EN: every adder saturates instead of wrapping.
module adder_tree #(
  parameter int WIDTH       = 17,
  parameter int INPUT_SIZE  = 32,
  parameter int OUTPUT_SIZE = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] input_data  [0:INPUT_SIZE-1][0:OUTPUT_SIZE-1],
  output logic signed [WIDTH-1:0] output_data [0:OUTPUT_SIZE-1]
);

  typedef logic signed [WIDTH-1:0] word_t;

  // A single operand still gets one register stage.
  localparam int LEVELS = (INPUT_SIZE <= 1) ? 1 : $clog2(INPUT_SIZE);

  // Element count at a given tree level; an unpaired tail element is carried upward.
  function automatic int level_count(input int lvl);
    int n;
    n = INPUT_SIZE;
    for (int i = 0; i < lvl; i++) n = (n + 1) / 2;
    return n;
  endfunction

  function automatic word_t add(input word_t a, input word_t b);
    word_t s;
    s = a + b;
`ifdef ADDER_TREE_SATURATE_EN
    if ((a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]))
      s = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    return s;
  endfunction

  for (genvar s = 0; s <= LEVELS; s++) begin : lvl
    localparam int N = level_count(s);
    word_t q [0:N-1][0:OUTPUT_SIZE-1];

    if (s == 0) begin : src
      assign q = input_data;
    end else begin : stg
      localparam int PN = level_count(s - 1);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          // NOTE: every pipeline register is reset (not just a valid bit) so no
          // pre-reset partial sum can ever reach output_data after release.
          for (int k = 0; k < N; k++)
            for (int c = 0; c < OUTPUT_SIZE; c++)
              q[k][c] <= '0;
        end else begin
          // NOTE: non-blocking so each level reads the previous level's old value.
          for (int k = 0; k < N; k++)
            for (int c = 0; c < OUTPUT_SIZE; c++)
              q[k][c] <= (2*k + 1 < PN)
                ? add(lvl[s-1].q[2*k][c], lvl[s-1].q[(2*k + 1 < PN) ? 2*k + 1 : 2*k][c])
                : lvl[s-1].q[2*k][c];
        end
      end
    end
  end

  // Output is the last register stage itself; no logic after it.
  always_comb begin
    for (int c = 0; c < OUTPUT_SIZE; c++)
      output_data[c] = lvl[LEVELS].q[0][c];
  end

endmodule

// File: tb/tb_adder_tree.sv
// Self-checking bench for adder_tree: table vectors on a 7x5 tree plus streaming,
// mid-operation reset, wrap/saturate (ADDER_TREE_SATURATE_EN) and 1/2-input trees.
module tb_adder_tree;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic signed [7:0] in7  [0:6][0:4];
  logic signed [7:0] out7 [0:4];
  logic signed [7:0] in8  [0:7][0:0];
  logic signed [7:0] out8 [0:0];
  logic signed [7:0] in1  [0:0][0:0];
  logic signed [7:0] out1 [0:0];
  logic signed [7:0] in2  [0:1][0:0];
  logic signed [7:0] out2 [0:0];

  adder_tree #(.WIDTH(8), .INPUT_SIZE(7), .OUTPUT_SIZE(5)) dut7 (
    .clk(clk), .reset(reset), .input_data(in7), .output_data(out7));
  adder_tree #(.WIDTH(8), .INPUT_SIZE(8), .OUTPUT_SIZE(1)) dut8 (
    .clk(clk), .reset(reset), .input_data(in8), .output_data(out8));
  adder_tree #(.WIDTH(8), .INPUT_SIZE(1), .OUTPUT_SIZE(1)) dut1 (
    .clk(clk), .reset(reset), .input_data(in1), .output_data(out1));
  adder_tree #(.WIDTH(8), .INPUT_SIZE(2), .OUTPUT_SIZE(1)) dut2 (
    .clk(clk), .reset(reset), .input_data(in2), .output_data(out2));

  typedef struct {
    string             name;
    logic signed [7:0] rows [0:6][0:4];
    int                exp  [0:4];
  } vec_t;

  vec_t tbl [0:3];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out7(input string name, input int base);
    for (int c = 0; c < 5; c++) check($sformatf("%s col%0d", name, c), int'(out7[c]), base + c);
  endtask

  task automatic check_out7_same(input string name, input int v [0:4]);
    for (int c = 0; c < 5; c++) check($sformatf("%s col%0d", name, c), int'(out7[c]), v[c]);
  endtask

  // Stream set j: sum of column c is j + c, spread over two rows that move each cycle.
  task automatic drive_stream(input int j);
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 5; c++) in7[r][c] = '0;
    for (int c = 0; c < 5; c++) begin
      in7[j % 7][c]       = 8'(j);
      in7[(j + 1) % 7][c] = 8'(c);
    end
  endtask

  initial begin
    int pat [0:6];
    int prev [0:4];
    int sat_pos, sat_neg, big_exp;

    pat = '{-1, 2, -3, 4, -5, 6, -7};
`ifdef ADDER_TREE_SATURATE_EN
    sat_pos = 127;  sat_neg = -128; big_exp = 127;
`else
    sat_pos = 32;   sat_neg = -32;  big_exp = 121;  // 7*127 = 889 = 121 mod 256
`endif

    tbl[0].name = "alt_rows";
    tbl[1].name = "col_const";
    tbl[2].name = "all_127";
    tbl[3].name = "zeros";
    for (int c = 0; c < 5; c++) begin
      for (int r = 0; r < 7; r++) begin
        tbl[0].rows[r][c] = 8'(pat[r]);
        tbl[1].rows[r][c] = 8'(c + 1);
        tbl[2].rows[r][c] = 8'sd127;
        tbl[3].rows[r][c] = '0;
      end
      tbl[0].exp[c] = -4;
      tbl[1].exp[c] = 7 * (c + 1);
      tbl[2].exp[c] = big_exp;
      tbl[3].exp[c] = 0;
    end

    for (int r = 0; r < 7; r++) for (int c = 0; c < 5; c++) in7[r][c] = '0;
    for (int r = 0; r < 8; r++) in8[r][0] = '0;
    in1[0][0] = '0;
    in2[0][0] = '0;
    in2[1][0] = '0;

    reset = 1'b1;
    #12;
    check("reset out7[0]", int'(out7[0]), 0);
    check("reset out8", int'(out8[0]), 0);
    check("reset out1", int'(out1[0]), 0);
    check("reset out2", int'(out2[0]), 0);
    reset = 1'b0;
    tick();

    // Table vectors: output must hold the previous result for two edges, then update on the third.
    for (int c = 0; c < 5; c++) prev[c] = 0;
    for (int v = 0; v < 4; v++) begin
      in7 = tbl[v].rows;
      tick();
      tick();
      check_out7_same({tbl[v].name, " lat-1"}, prev);
      tick();
      check_out7_same(tbl[v].name, tbl[v].exp);
      prev = tbl[v].exp;
    end

    // Streaming: one new set per cycle, results in order with no gaps.
    for (int i = 1; i <= 12; i++) begin
      if (i <= 10) drive_stream(i);
      else drive_stream(0);
      tick();
      if (i >= 3) check_out7($sformatf("stream set%0d", i - 2), i - 2);
    end

    // Fill pipeline with nonzero sets, then reset mid-cycle.
    for (int j = 20; j <= 23; j++) begin
      drive_stream(j);
      tick();
    end
    check_out7("prefill", 21);
    #2;
    reset = 1'b1;
    #1;
    check_out7_same("async reset", '{0, 0, 0, 0, 0});
    tick();
    check_out7_same("reset held", '{0, 0, 0, 0, 0});
    #2;
    reset = 1'b0;
    drive_stream(5);
    tick();
    drive_stream(0);
    check_out7_same("post-reset lat1", '{0, 0, 0, 0, 0});
    tick();
    check_out7_same("post-reset lat2", '{0, 0, 0, 0, 0});
    tick();
    check_out7("post-reset first", 5);
    tick();
    check_out7("post-reset zero set", 0);

    // 8-input wrap / saturation.
    for (int r = 0; r < 8; r++) in8[r][0] = 8'sd100;
    tick();
    tick();
    check("all_100 lat-1", int'(out8[0]), 0);
    tick();
    check("all_100", int'(out8[0]), sat_pos);
    for (int r = 0; r < 8; r++) in8[r][0] = -8'sd100;
    tick();
    tick();
    tick();
    check("all_m100", int'(out8[0]), sat_neg);

    // Single-input and two-input trees: one stage of latency.
    in1[0][0] = 8'sd5;
    in2[0][0] = 8'sd3;
    in2[1][0] = -8'sd4;
    #2;
    check("in1 before edge", int'(out1[0]), 0);
    check("in2 before edge", int'(out2[0]), 0);
    tick();
    check("in1 pass", int'(out1[0]), 5);
    check("in2 sum", int'(out2[0]), -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
